fsm_diagram_seq: RTL and testbench

- Five-state Moore finite-state machine, implemented from a state diagram.
- Advances on each rising edge of clock `flux`, driven by the 1-bit serial input `in`.
- Exposes the current state as one-hot flags A..E and drives a single Moore output `out`.
- Leaf control block; no parameters, no handshake.

---
 rtl/fsm_diagram_pkg.sv | 14 +
 rtl/fsm_diagram_seq.sv | 80 ++++++++
 tb/tb_fsm_diagram_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/fsm_diagram_pkg.sv
// Shared types for the five-state diagram FSM: state encoding and reset state.
package fsm_diagram_pkg;

   typedef enum logic [2:0] {
      S_A = 3'd0,
      S_B = 3'd1,
      S_C = 3'd2,
      S_D = 3'd3,
      S_E = 3'd4
   } state_t;

   localparam state_t RESET_STATE = S_A;

endpackage

// File: rtl/fsm_diagram_seq.sv
// Five-state Moore FSM driven by serial input `in`.
// State is decoded to one-hot flags A..E, and out is high only in state D.
module fsm_diagram_seq
   import fsm_diagram_pkg::*;
(
   input  logic flux,
   input  logic reset,
   input  logic in,
   output logic out,
   output logic A,
   output logic B,
   output logic C,
   output logic D,
   output logic E
);

   state_t state_q;
   state_t state_d;

   always_ff @(posedge flux) begin
      if (!reset) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   // An unknown `in` or an unused state encoding falls through to the reset state.
   always_comb begin
      state_d = RESET_STATE;
      case (state_q)
         S_A: begin
            case (in)
               1'b0:    state_d = S_B;
               1'b1:    state_d = S_C;
               default: state_d = RESET_STATE;
            endcase
         end
         S_B: begin
            case (in)
               1'b0:    state_d = S_B;
               1'b1:    state_d = S_D;
               default: state_d = RESET_STATE;
            endcase
         end
         S_C: begin
            case (in)
               1'b0:    state_d = S_E;
               1'b1:    state_d = S_C;
               default: state_d = RESET_STATE;
            endcase
         end
         S_D: begin
            case (in)
               1'b0:    state_d = S_E;
               1'b1:    state_d = S_C;
               default: state_d = RESET_STATE;
            endcase
         end
         S_E: begin
            case (in)
               1'b0:    state_d = S_B;
               1'b1:    state_d = S_D;
               default: state_d = RESET_STATE;
            endcase
         end
         default: state_d = RESET_STATE;
      endcase
   end

   always_comb begin
      A   = (state_q == S_A);
      B   = (state_q == S_B);
      C   = (state_q == S_C);
      D   = (state_q == S_D);
      E   = (state_q == S_E);
      out = (state_q == S_D);
   end

endmodule

// File: tb/tb_fsm_diagram_seq.sv
// Directed bench for fsm_diagram_seq.
// The flags are compared as a packed vector {A,B,C,D,E,out}.
module tb_fsm_diagram_seq;

   logic flux;
   logic reset;
   logic in;
   logic out;
   logic A;
   logic B;
   logic C;
   logic D;
   logic E;

   int total = 0;
   int bad   = 0;

   localparam logic [5:0] EA = 6'b100000;
   localparam logic [5:0] EB = 6'b010000;
   localparam logic [5:0] EC = 6'b001000;
   localparam logic [5:0] ED = 6'b000101;
   localparam logic [5:0] EE = 6'b000010;

   fsm_diagram_seq dut (
      .flux  (flux),
      .reset (reset),
      .in    (in),
      .out   (out),
      .A     (A),
      .B     (B),
      .C     (C),
      .D     (D),
      .E     (E)
   );

   initial flux = 1'b0;
   always #5 flux = ~flux;

   task automatic check_val(input string tag, input logic [5:0] got, input logic [5:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   // Apply one edge with the given reset/in, then check the flags and the one-hot property.
   task automatic step(input logic r, input logic i, input string tag, input logic [5:0] exp);
      logic [5:0] flags;
      @(negedge flux);
      reset = r;
      in    = i;
      @(posedge flux);
      #1;
      flags = {A, B, C, D, E, out};
      check_val(tag, flags, exp);
      check_val({tag, "_onehot"}, 6'($countones({A, B, C, D, E})), 6'd1);
   endtask

   task automatic go_to(input int s);
      step(1'b0, 1'b0, "goto_rst", EA);
      case (s)
         1: step(1'b1, 1'b0, "goto_b", EB);
         2: step(1'b1, 1'b1, "goto_c", EC);
         3: begin
            step(1'b1, 1'b0, "goto_d0", EB);
            step(1'b1, 1'b1, "goto_d1", ED);
         end
         4: begin
            step(1'b1, 1'b1, "goto_e0", EC);
            step(1'b1, 1'b0, "goto_e1", EE);
         end
         default: ;
      endcase
   endtask

   logic       walk_in  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic [5:0] walk_exp [9] = '{EC, EE, ED, EE, EB, EB, ED, EC, EC};
   // Expected next state, indexed by state*2 + in, for states A..E.
   logic [5:0] trans_exp [10] = '{EB, EC, EB, ED, EE, EC, EE, EC, EB, ED};

   initial begin
      reset = 1'b0;
      in    = 1'b0;

      step(1'b0, 1'bx, "reset_start", EA);

      for (int k = 0; k < 9; k++) begin
         step(1'b1, walk_in[k], $sformatf("walk%0d", k), walk_exp[k]);
      end

      step(1'b0, 1'b1, "mid_reset", EA);
      step(1'b1, 1'b0, "mid_reset_b", EB);

      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, $sformatf("bloop%0d", k), EB);
      step(1'b1, 1'b1, "to_d", ED);
      step(1'b1, 1'b1, "to_c", EC);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, $sformatf("cloop%0d", k), EC);

      for (int s = 0; s < 5; s++) begin
         for (int i = 0; i < 2; i++) begin
            go_to(s);
            step(1'b1, i[0], $sformatf("trans_s%0d_in%0d", s, i), trans_exp[s*2+i]);
         end
      end

      go_to(4);
      step(1'b0, 1'b0, "reset_prio", EA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
